// File: rtl/encrypt_round_ctrl.sv
// Multi-round block encryption sequencer around one combinational encrypt_engine.
// Optional ENC_STATS_EN adds a 16-bit delivered-block counter output (blocks_done).

module encrypt_engine #(
  parameter int unsigned BLOCK_WIDTH = 32
) (
  input  logic [BLOCK_WIDTH-1:0] data_i,
  input  logic [BLOCK_WIDTH-1:0] key_i,
  output logic [BLOCK_WIDTH-1:0] data_o
);
  logic [BLOCK_WIDTH-1:0] mixed;

  assign mixed  = data_i ^ key_i;
  assign data_o = {mixed[BLOCK_WIDTH-2:0], mixed[BLOCK_WIDTH-1]};
endmodule

module encrypt_round_ctrl #(
  parameter int unsigned BLOCK_WIDTH = 32,
  parameter int unsigned NUM_ROUNDS  = 8,
  parameter int unsigned KEY_ROT     = 3
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              flush,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [BLOCK_WIDTH-1:0]            in_data,
  input  logic [BLOCK_WIDTH-1:0]            in_key,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [BLOCK_WIDTH-1:0]            out_data,
  output logic                              busy,
  output logic [$clog2(NUM_ROUNDS+1)-1:0]   round_idx
`ifdef ENC_STATS_EN
  ,
  output logic [15:0]                       blocks_done
`endif
);
  localparam int unsigned RW = $clog2(NUM_ROUNDS + 1);

  if (NUM_ROUNDS < 1) begin : g_bad_rounds
    $error("encrypt_round_ctrl: NUM_ROUNDS must be at least 1");
  end
  if (KEY_ROT < 1 || KEY_ROT >= BLOCK_WIDTH) begin : g_bad_rot
    $error("encrypt_round_ctrl: KEY_ROT must be in 1..BLOCK_WIDTH-1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e                 state_q;
  logic                   in_ready_q;
  logic                   out_valid_q;
  logic                   busy_q;
  logic [RW-1:0]          round_q;
  logic [BLOCK_WIDTH-1:0] data_q;
  logic [BLOCK_WIDTH-1:0] key_q;

  logic [BLOCK_WIDTH-1:0] data_d;
  logic [BLOCK_WIDTH-1:0] key_d;
  logic [BLOCK_WIDTH-1:0] round_const;
  logic                   last_round;

  encrypt_engine #(
    .BLOCK_WIDTH(BLOCK_WIDTH)
  ) u_engine (
    .data_i(data_q),
    .key_i (key_q),
    .data_o(data_d)
  );

  // Next round key: rotate, then mix in the 1-based round number zero-extended.
  always_comb begin
    round_const = BLOCK_WIDTH'(round_q) + BLOCK_WIDTH'(1);
    key_d       = ((key_q << KEY_ROT) | (key_q >> (BLOCK_WIDTH - KEY_ROT))) ^ round_const;
    last_round  = (round_q == RW'(NUM_ROUNDS - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      round_q     <= '0;
      data_q      <= '0;
      key_q       <= '0;
    end else if (flush) begin
      // Abort wins over everything; data/key registers intentionally keep their value.
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      round_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            data_q     <= in_data;
            key_q      <= in_key;
            round_q    <= '0;
            state_q    <= S_RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        S_RUN: begin
          data_q  <= data_d;
          key_q   <= key_d;
          round_q <= round_q + RW'(1);
          if (last_round) begin
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            round_q     <= '0;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          round_q     <= '0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign round_idx = round_q;
  assign out_data  = data_q;

`ifdef ENC_STATS_EN
  logic [15:0] blocks_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blocks_q <= '0;
    end else if (out_valid_q && out_ready && !flush) begin
      blocks_q <= blocks_q + 16'd1;
    end
  end

  assign blocks_done = blocks_q;
`endif

endmodule

// File: tb/tb_encrypt_round_ctrl.sv
// Directed bench for encrypt_round_ctrl with NUM_ROUNDS = 1, 2 and 8 instances.

module tb_encrypt_round_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        out_ready;
  logic [31:0] in_data;
  logic [31:0] in_key;
  logic        iv1, iv2, iv8;

  logic        ir1, ov1, busy1;
  logic        ir2, ov2, busy2;
  logic        ir8, ov8, busy8;
  logic [31:0] od1, od2, od8;
  logic [0:0]  ri1;
  logic [1:0]  ri2;
  logic [3:0]  ri8;
`ifdef ENC_STATS_EN
  logic [15:0] bd1, bd2, bd8;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  encrypt_round_ctrl #(.BLOCK_WIDTH(32), .NUM_ROUNDS(1), .KEY_ROT(3)) u1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(iv1), .in_ready(ir1),
    .in_data(in_data), .in_key(in_key), .out_valid(ov1), .out_ready(out_ready),
    .out_data(od1), .busy(busy1), .round_idx(ri1)
`ifdef ENC_STATS_EN
    , .blocks_done(bd1)
`endif
  );

  encrypt_round_ctrl #(.BLOCK_WIDTH(32), .NUM_ROUNDS(2), .KEY_ROT(3)) u2 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(iv2), .in_ready(ir2),
    .in_data(in_data), .in_key(in_key), .out_valid(ov2), .out_ready(out_ready),
    .out_data(od2), .busy(busy2), .round_idx(ri2)
`ifdef ENC_STATS_EN
    , .blocks_done(bd2)
`endif
  );

  encrypt_round_ctrl #(.BLOCK_WIDTH(32), .NUM_ROUNDS(8), .KEY_ROT(3)) u8 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(iv8), .in_ready(ir8),
    .in_data(in_data), .in_key(in_key), .out_valid(ov8), .out_ready(out_ready),
    .out_data(od8), .busy(busy8), .round_idx(ri8)
`ifdef ENC_STATS_EN
    , .blocks_done(bd8)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Independent reference: rotl1(data ^ key), key = rotl3(key) ^ (r+1).
  function automatic logic [31:0] ref_enc(input logic [31:0] d, input logic [31:0] k,
                                          input int unsigned nr);
    logic [31:0] x;
    for (int unsigned r = 0; r < nr; r++) begin
      x = d ^ k;
      d = {x[30:0], x[31]};
      k = {k[28:0], k[31:29]} ^ (r + 1);
    end
    return d;
  endfunction

  task automatic send8(input logic [31:0] d, input logic [31:0] k);
    check("send_ready", {31'd0, ir8}, 32'd1);
    in_data = d;
    in_key  = k;
    iv8     = 1'b1;
    tick();
    iv8     = 1'b0;
  endtask

  task automatic wait_ov8(output int n);
    n = 0;
    while (!ov8 && n < 30) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int          n;
    int          cyc;
    int          blk;
    int          outs;
    int          acc[3];
    logic        saw;
    logic [31:0] d_tab[3];
    logic [31:0] k_tab[3];
    logic [31:0] e_tab[3];
    logic [31:0] held;
`ifdef ENC_STATS_EN
    logic [15:0] bd_base;
`endif

    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    iv1 = 1'b0; iv2 = 1'b0; iv8 = 1'b0;
    in_data = '0; in_key = '0;

    #12;
    check("rst_in_ready", {31'd0, ir8}, 32'd1);
    check("rst_out_valid", {31'd0, ov8}, 32'd0);
    check("rst_busy", {31'd0, busy8}, 32'd0);
    check("rst_out_data", od8, 32'd0);
    check("rst_round_idx", {28'd0, ri8}, 32'd0);
    #1 rst_n = 1'b1;
    tick();

    // NUM_ROUNDS=1 hand vector
    in_data = 32'h1234_5678; in_key = 32'hDEAD_BEEF; iv1 = 1'b1;
    tick();
    iv1 = 1'b0;
    check("r1_busy", {31'd0, busy1}, 32'd1);
    check("r1_valid_early", {31'd0, ov1}, 32'd0);
    tick();
    check("r1_valid", {31'd0, ov1}, 32'd1);
    check("r1_data", od1, 32'h9933_D12F);
    check("r1_round_idx", {31'd0, ri1}, 32'd1);
    tick();
    check("r1_idle_valid", {31'd0, ov1}, 32'd0);
    check("r1_idle_ready", {31'd0, ir1}, 32'd1);

    // NUM_ROUNDS=2, zero data and key
    in_data = '0; in_key = '0; iv2 = 1'b1;
    tick();
    iv2 = 1'b0;
    tick();
    check("r2_mid_valid", {31'd0, ov2}, 32'd0);
    check("r2_mid_idx", {30'd0, ri2}, 32'd1);
    tick();
    check("r2_valid", {31'd0, ov2}, 32'd1);
    check("r2_data", od2, 32'h0000_0002);
    check("r2_round_idx", {30'd0, ri2}, 32'd2);
    tick();

    // NUM_ROUNDS=8 with backpressure
    out_ready = 1'b0;
    send8(32'd0, 32'd0);
    in_data = 32'hFFFF_FFFF; in_key = 32'hA5A5_A5A5;
    wait_ov8(n);
    check("r8_latency", n, 32'd8);
    check("r8_data", od8, 32'h0008_68DE);
    check("r8_round_idx", {28'd0, ri8}, 32'd8);
    held = od8;
    saw  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      saw = saw & ov8 & ~ir8 & busy8 & (od8 == held);
    end
    check("r8_stall_stable", {31'd0, saw}, 32'd1);
    out_ready = 1'b1;
    tick();
    check("r8_hs_valid", {31'd0, ov8}, 32'd0);
    check("r8_hs_ready", {31'd0, ir8}, 32'd1);
    check("r8_hs_busy", {31'd0, busy8}, 32'd0);
    check("r8_hs_idx", {28'd0, ri8}, 32'd0);

    // Back-to-back, in_valid held high
    d_tab[0] = 32'd0;          k_tab[0] = 32'd0;          e_tab[0] = 32'h0008_68DE;
    d_tab[1] = 32'h1234_5678;  k_tab[1] = 32'hDEAD_BEEF;
    d_tab[2] = 32'hCAFE_F00D;  k_tab[2] = 32'h0BAD_C0DE;
    e_tab[1] = ref_enc(d_tab[1], k_tab[1], 8);
    e_tab[2] = ref_enc(d_tab[2], k_tab[2], 8);
`ifdef ENC_STATS_EN
    bd_base = bd8;
`endif
    check("b2b_ready0", {31'd0, ir8}, 32'd1);
    in_data = d_tab[0]; in_key = k_tab[0]; iv8 = 1'b1;
    acc[0] = 0; blk = 1; outs = 0;
    acc[1] = -1; acc[2] = -1;
    for (cyc = 1; cyc < 60 && outs < 3; cyc++) begin
      tick();
      if (ov8) begin
        check("b2b_data", od8, e_tab[outs]);
        outs++;
      end
      if (ir8 && blk < 3) begin
        in_data = d_tab[blk]; in_key = k_tab[blk];
        acc[blk] = cyc;
        blk++;
      end
    end
    iv8 = 1'b0;
    check("b2b_count", outs, 32'd3);
    check("b2b_space1", acc[1] - acc[0], 32'd10);
    check("b2b_space2", acc[2] - acc[1], 32'd10);
    tick();
`ifdef ENC_STATS_EN
    check("b2b_blocks_done", {16'd0, bd8 - bd_base}, 32'd3);
`endif

    // Flush mid-run at round 3
    send8(32'h0F0F_0F0F, 32'h1111_1111);
    n = 0;
    while (ri8 != 4'd3 && n < 20) begin
      tick();
      n++;
    end
    check("fl_reach_r3", {28'd0, ri8}, 32'd3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_ready", {31'd0, ir8}, 32'd1);
    check("fl_busy", {31'd0, busy8}, 32'd0);
    check("fl_idx", {28'd0, ri8}, 32'd0);
    saw = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      saw = saw | ov8;
    end
    check("fl_no_valid", {31'd0, saw}, 32'd0);

    // Flush together with in_valid in IDLE: nothing accepted
    flush = 1'b1; iv8 = 1'b1;
    tick();
    flush = 1'b0; iv8 = 1'b0;
    check("fl_idle_busy", {31'd0, busy8}, 32'd0);
    check("fl_idle_ready", {31'd0, ir8}, 32'd1);
    tick();
    check("fl_idle_busy2", {31'd0, busy8}, 32'd0);

    // Flush with out_ready in DONE drops the block
`ifdef ENC_STATS_EN
    bd_base = bd8;
`endif
    out_ready = 1'b0;
    send8(32'h5555_AAAA, 32'h0000_0001);
    wait_ov8(n);
    check("fd_latency", n, 32'd8);
    flush = 1'b1; out_ready = 1'b1;
    tick();
    flush = 1'b0;
    check("fd_valid", {31'd0, ov8}, 32'd0);
    check("fd_ready", {31'd0, ir8}, 32'd1);
`ifdef ENC_STATS_EN
    check("fd_blocks_done", {16'd0, bd8 - bd_base}, 32'd0);
`endif

    // Asynchronous reset mid-run
    send8(32'h1234_5678, 32'hDEAD_BEEF);
    tick(); tick(); tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid", {31'd0, ov8}, 32'd0);
    check("ar_busy", {31'd0, busy8}, 32'd0);
    check("ar_idx", {28'd0, ri8}, 32'd0);
    check("ar_ready", {31'd0, ir8}, 32'd1);
    #3 rst_n = 1'b1;
    tick();
    send8(32'hCAFE_F00D, 32'h0BAD_C0DE);
    wait_ov8(n);
    check("ar_latency", n, 32'd8);
    check("ar_data", od8, ref_enc(32'hCAFE_F00D, 32'h0BAD_C0DE, 8));
    tick();
    check("ar_done_ready", {31'd0, ir8}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
